cpu_data_ram: RTL and testbench

Data-memory responder for the 4-bit CPU's RAM port: it receives the CPU's `ram_RW`/`ram_EN`/address/write-data accesses and returns read data. It holds 240 nibbles of scratch RAM plus a small memory-mapped I/O page (output port, synchronised input port, timer, LFSR random source, status). After every reset a scrub engine zeroes the RAM before accesses are served. It sits between the CPU core and the board pins.

---
 rtl/cpu_data_ram.sv | 183 ++++++++++++++++++
 tb/tb_cpu_data_ram.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_data_ram.sv
// Data-memory responder for the 4-bit CPU: 240-nibble scrubbed RAM plus a memory-mapped
// I/O page (output port, synchronised input, timer, LFSR random source, status).
module cpu_data_ram #(
   parameter logic [7:0]  IO_BASE   = 8'hF0,
   parameter logic [3:0]  LFSR_SEED = 4'b0001,
   parameter int unsigned TIMER_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ram_RW,
   input  logic       ram_EN,
   input  logic [7:0] ram_address_bus,
   input  logic [3:0] ram_data_bus_out,
   output logic [3:0] ram_data_bus_in,
   input  logic [3:0] io_in,
   output logic [3:0] io_out,
   output logic       io_out_strobe,
   output logic       ram_busy
);

   localparam logic [15:0] PRESC_MAX = 16'(TIMER_DIV - 1);
   localparam logic [7:0]  LAST_ADDR = IO_BASE - 8'd1;

   typedef enum logic {ST_SCRUB = 1'b0, ST_READY = 1'b1} state_t;

   function automatic logic [3:0] lfsr_next(input logic [3:0] q);
      return {q[2:0], q[3] ^ q[2]};
   endfunction

   state_t      state_r, state_s;
   logic [7:0]  ptr_r, ptr_s;
   logic [3:0]  mem_r [0:int'(IO_BASE)-1];
   logic [3:0]  sync1_r, sync2_r;
   logic [7:0]  timer_r;
   logic [15:0] presc_r;
   logic [3:0]  shadow_r;
   logic [3:0]  lfsr_r;
   logic        ovf_r;

   logic        scrub_we_s, rd_s, wr_s, is_ram_s;
   logic [7:0]  io_off_s;
   logic [3:0]  rd_data_s;
   logic        out_wr_s, timlo_rd_s, timlo_wr_s, rand_rd_s, rand_wr_s, status_rd_s;
   logic        tick_s, wrap_s;

   // Scrub FSM state and pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_SCRUB;
         ptr_r   <= 8'd0;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
      end
   end

   // Scrub FSM next-state: walk the RAM once, then serve accesses
   always_comb begin
      state_s    = state_r;
      ptr_s      = ptr_r;
      scrub_we_s = 1'b0;
      case (state_r)
         ST_SCRUB: begin
            scrub_we_s = !rst;
            if (ptr_r == LAST_ADDR) begin
               state_s = ST_READY;
               ptr_s   = 8'd0;
            end else begin
               ptr_s = ptr_r + 8'd1;
            end
         end
         ST_READY: begin
            state_s = ST_READY;
         end
         default: begin
            state_s = ST_SCRUB;
            ptr_s   = 8'd0;
         end
      endcase
   end

   assign ram_busy = (state_r == ST_SCRUB);

   // Access decode and read-data mux
   always_comb begin
      rd_s        = ram_EN && (state_r == ST_READY) && ram_RW;
      wr_s        = ram_EN && (state_r == ST_READY) && !ram_RW;
      is_ram_s    = (ram_address_bus < IO_BASE);
      io_off_s    = ram_address_bus - IO_BASE;
      out_wr_s    = wr_s && !is_ram_s && (io_off_s == 8'd0);
      timlo_rd_s  = rd_s && !is_ram_s && (io_off_s == 8'd2);
      timlo_wr_s  = wr_s && !is_ram_s && (io_off_s == 8'd2);
      rand_rd_s   = rd_s && !is_ram_s && (io_off_s == 8'd4);
      rand_wr_s   = wr_s && !is_ram_s && (io_off_s == 8'd4);
      status_rd_s = rd_s && !is_ram_s && (io_off_s == 8'd5);
      rd_data_s   = 4'h0;
      if (is_ram_s) begin
         rd_data_s = mem_r[ram_address_bus];
      end else begin
         case (io_off_s)
            8'd0:    rd_data_s = io_out;
            8'd1:    rd_data_s = sync2_r;
            8'd2:    rd_data_s = timer_r[3:0];
            8'd3:    rd_data_s = shadow_r;
            8'd4:    rd_data_s = lfsr_r;
            8'd5:    rd_data_s = {2'b00, ovf_r, 1'b1};
            default: rd_data_s = 4'h0;
         endcase
      end
   end

   // RAM array: scrub zeroing has priority over CPU writes (they never coincide)
   always_ff @(posedge clk) begin
      if (scrub_we_s) begin
         mem_r[ptr_r] <= 4'h0;
      end else if (wr_s && is_ram_s) begin
         mem_r[ram_address_bus] <= ram_data_bus_out;
      end
   end

   // Prescaler tick and timer wrap; a TIMLO write suppresses the tick
   always_comb begin
      tick_s = (presc_r == PRESC_MAX) && !timlo_wr_s;
      wrap_s = tick_s && (timer_r == 8'hFF);
   end

   // Read data, output port, synchroniser, LFSR and shadow registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_data_bus_in <= 4'h0;
         io_out          <= 4'h0;
         io_out_strobe   <= 1'b0;
         sync1_r         <= 4'h0;
         sync2_r         <= 4'h0;
         shadow_r        <= 4'h0;
         lfsr_r          <= LFSR_SEED;
      end else begin
         sync1_r       <= io_in;
         sync2_r       <= sync1_r;
         io_out_strobe <= out_wr_s;
         if (rd_s) begin
            ram_data_bus_in <= rd_data_s;
         end
         if (out_wr_s) begin
            io_out <= ram_data_bus_out;
         end
         if (timlo_rd_s) begin
            shadow_r <= timer_r[7:4];
         end
         if (rand_wr_s) begin
            lfsr_r <= (ram_data_bus_out == 4'h0) ? LFSR_SEED : ram_data_bus_out;
         end else if (rand_rd_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
         end
      end
   end

   // Timer, prescaler and sticky overflow (set beats a STATUS-read clear)
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r <= 16'd0;
         timer_r <= 8'd0;
         ovf_r   <= 1'b0;
      end else begin
         if (timlo_wr_s || (presc_r == PRESC_MAX)) begin
            presc_r <= 16'd0;
         end else begin
            presc_r <= presc_r + 16'd1;
         end
         if (timlo_wr_s) begin
            timer_r <= 8'd0;
         end else if (tick_s) begin
            timer_r <= timer_r + 8'd1;
         end
         if (wrap_s) begin
            ovf_r <= 1'b1;
         end else if (status_rd_s) begin
            ovf_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cpu_data_ram.sv
// Directed self-checking bench for cpu_data_ram with hand-computed expectations.
module tb_cpu_data_ram;

   logic       clk = 1'b0;
   logic       rst;
   logic       ram_RW;
   logic       ram_EN;
   logic [7:0] ram_address_bus;
   logic [3:0] ram_data_bus_out;
   logic [3:0] ram_data_bus_in;
   logic [3:0] io_in;
   logic [3:0] io_out;
   logic       io_out_strobe;
   logic       ram_busy;

   int checks_n = 0;
   int fails_n  = 0;
   int edge_n   = 0;
   int w_edge;
   logic [7:0] tim_exp;

   cpu_data_ram dut (
      .clk              (clk),
      .rst              (rst),
      .ram_RW           (ram_RW),
      .ram_EN           (ram_EN),
      .ram_address_bus  (ram_address_bus),
      .ram_data_bus_out (ram_data_bus_out),
      .ram_data_bus_in  (ram_data_bus_in),
      .io_in            (io_in),
      .io_out           (io_out),
      .io_out_strobe    (io_out_strobe),
      .ram_busy         (ram_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks_n++;
      if (got !== exp) begin
         fails_n++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic acc(input logic rw, input logic [7:0] a, input logic [3:0] d);
      ram_EN           = 1'b1;
      ram_RW           = rw;
      ram_address_bus  = a;
      ram_data_bus_out = d;
      tick();
      ram_EN = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ram_RW = 1'b1; ram_EN = 1'b0;
      ram_address_bus = 8'h00; ram_data_bus_out = 4'h0; io_in = 4'h0;
      tick(); tick();
      chk("rst_busy", {7'd0, ram_busy}, 8'd1);
      chk("rst_rdata", {4'd0, ram_data_bus_in}, 8'd0);
      chk("rst_io_out", {4'd0, io_out}, 8'd0);
      chk("rst_strobe", {7'd0, io_out_strobe}, 8'd0);

      // Scrub: accesses during busy are ignored
      rst = 1'b0; edge_n = 0;
      repeat (199) tick();
      chk("busy_199", {7'd0, ram_busy}, 8'd1);
      acc(1'b0, 8'h10, 4'hF);
      acc(1'b0, 8'hF0, 4'h7);
      chk("busy_out_ignored", {4'd0, io_out}, 8'd0);
      chk("busy_strobe", {7'd0, io_out_strobe}, 8'd0);
      acc(1'b1, 8'hF4, 4'h0);
      chk("busy_rd_ignored", {4'd0, ram_data_bus_in}, 8'd0);
      while (edge_n < 239) tick();
      chk("busy_239", {7'd0, ram_busy}, 8'd1);
      tick();
      chk("busy_fall_240", {7'd0, ram_busy}, 8'd0);

      // Scrubbed RAM reads zero; first non-busy cycle is served
      acc(1'b0, 8'h7F, 4'h6);
      acc(1'b1, 8'h7F, 4'h0);
      chk("first_ready_wr", {4'd0, ram_data_bus_in}, 8'h6);
      acc(1'b1, 8'h00, 4'h0);
      chk("rd_00", {4'd0, ram_data_bus_in}, 8'h0);
      acc(1'b1, 8'hEF, 4'h0);
      chk("rd_EF", {4'd0, ram_data_bus_in}, 8'h0);
      acc(1'b1, 8'h10, 4'h0);
      chk("rd_10_ignored_wr", {4'd0, ram_data_bus_in}, 8'h0);

      // RAM write/read and hold
      acc(1'b0, 8'h10, 4'hA);
      acc(1'b1, 8'h10, 4'h0);
      chk("rd_10", {4'd0, ram_data_bus_in}, 8'hA);
      tick();
      chk("hold_idle", {4'd0, ram_data_bus_in}, 8'hA);
      acc(1'b0, 8'h11, 4'h3);
      chk("hold_write", {4'd0, ram_data_bus_in}, 8'hA);
      acc(1'b1, 8'h11, 4'h0);
      chk("rd_11", {4'd0, ram_data_bus_in}, 8'h3);

      // OUT port and strobe
      acc(1'b0, 8'hF0, 4'h5);
      chk("out_val", {4'd0, io_out}, 8'h5);
      chk("out_strobe", {7'd0, io_out_strobe}, 8'd1);
      tick();
      chk("out_strobe_end", {7'd0, io_out_strobe}, 8'd0);
      acc(1'b0, 8'hF0, 4'h6);
      acc(1'b0, 8'hF0, 4'h7);
      chk("out_b2b_strobe", {7'd0, io_out_strobe}, 8'd1);
      chk("out_b2b_val", {4'd0, io_out}, 8'h7);
      acc(1'b1, 8'hF0, 4'h0);
      chk("out_rd", {4'd0, ram_data_bus_in}, 8'h7);
      chk("out_rd_no_strobe", {7'd0, io_out_strobe}, 8'd0);

      // IN port through synchroniser; writes ignored
      io_in = 4'h9;
      repeat (3) tick();
      acc(1'b0, 8'hF1, 4'h2);
      acc(1'b1, 8'hF1, 4'h0);
      chk("in_rd", {4'd0, ram_data_bus_in}, 8'h9);

      // RAND sequence and loads
      acc(1'b1, 8'hF4, 4'h0); chk("rand_0", {4'd0, ram_data_bus_in}, 8'h1);
      acc(1'b1, 8'hF4, 4'h0); chk("rand_1", {4'd0, ram_data_bus_in}, 8'h2);
      acc(1'b1, 8'hF4, 4'h0); chk("rand_2", {4'd0, ram_data_bus_in}, 8'h4);
      acc(1'b1, 8'hF4, 4'h0); chk("rand_3", {4'd0, ram_data_bus_in}, 8'h9);
      acc(1'b0, 8'hF4, 4'h0);
      acc(1'b1, 8'hF4, 4'h0); chk("rand_seed", {4'd0, ram_data_bus_in}, 8'h1);
      acc(1'b0, 8'hF4, 4'hC);
      acc(1'b1, 8'hF4, 4'h0); chk("rand_load", {4'd0, ram_data_bus_in}, 8'hC);
      acc(1'b1, 8'hF4, 4'h0); chk("rand_step", {4'd0, ram_data_bus_in}, 8'h8);

      // Unmapped I/O reads zero
      acc(1'b1, 8'hF6, 4'h0); chk("rd_F6", {4'd0, ram_data_bus_in}, 8'h0);
      acc(1'b1, 8'h11, 4'h0);
      acc(1'b1, 8'hFF, 4'h0); chk("rd_FF", {4'd0, ram_data_bus_in}, 8'h0);

      // Timer low/high via shadow
      tim_exp = 8'(edge_n / 4);
      acc(1'b1, 8'hF2, 4'h0); chk("tim_lo", {4'd0, ram_data_bus_in}, {4'd0, tim_exp[3:0]});
      acc(1'b1, 8'hF3, 4'h0); chk("tim_hi", {4'd0, ram_data_bus_in}, {4'd0, tim_exp[7:4]});
      acc(1'b1, 8'hF5, 4'h0); chk("status_no_ovf", {4'd0, ram_data_bus_in}, 8'h1);

      // First overflow at edge 1024 after release
      while (edge_n < 1030) tick();
      acc(1'b1, 8'hF5, 4'h0); chk("status_ovf", {4'd0, ram_data_bus_in}, 8'h3);
      acc(1'b1, 8'hF5, 4'h0); chk("status_cleared", {4'd0, ram_data_bus_in}, 8'h1);

      // Overflow coincident with STATUS read: set wins
      acc(1'b0, 8'hF2, 4'h5);
      w_edge = edge_n;
      acc(1'b1, 8'hF2, 4'h0); chk("tim_cleared", {4'd0, ram_data_bus_in}, 8'h0);
      while (edge_n < w_edge + 1023) tick();
      acc(1'b1, 8'hF5, 4'h0); chk("status_coinc", {4'd0, ram_data_bus_in}, 8'h1);
      acc(1'b1, 8'hF5, 4'h0); chk("status_set_wins", {4'd0, ram_data_bus_in}, 8'h3);

      // Reset asserted during a read
      acc(1'b1, 8'h10, 4'h0); chk("pre_rst_rd", {4'd0, ram_data_bus_in}, 8'hA);
      rst = 1'b1;
      acc(1'b1, 8'h10, 4'h0);
      chk("rst_mid_read", {4'd0, ram_data_bus_in}, 8'h0);
      chk("rst_busy2", {7'd0, ram_busy}, 8'd1);
      chk("rst_io_out2", {4'd0, io_out}, 8'h0);

      // Mid-scrub reset restarts the scrub
      rst = 1'b0; edge_n = 0;
      while (edge_n < 99) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; edge_n = 0;
      while (edge_n < 239) tick();
      chk("rescrub_busy_239", {7'd0, ram_busy}, 8'd1);
      tick();
      chk("rescrub_fall_240", {7'd0, ram_busy}, 8'd0);
      acc(1'b1, 8'h10, 4'h0); chk("rescrub_rd_10", {4'd0, ram_data_bus_in}, 8'h0);
      acc(1'b1, 8'h11, 4'h0);
      acc(1'b1, 8'hF3, 4'h0); chk("shadow_reset", {4'd0, ram_data_bus_in}, 8'h0);
      acc(1'b1, 8'hF4, 4'h0); chk("lfsr_reset", {4'd0, ram_data_bus_in}, 8'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks_n, fails_n);
      $finish;
   end

endmodule
